// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM state encoding and serial line levels.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   localparam logic TX_IDLE  = 1'b1;
   localparam logic TX_START = 1'b0;

endpackage

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: one-entry holding register, frame FSM and parity,
// driving an external shift serializer paced by the baud tick.
module uart_tx_ctrl
   import uart_pkg::*;
#(
   parameter int DATAWIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 baud_tick,
   input  logic [DATAWIDTH-1:0] in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 par_en,
   input  logic                 par_odd,
   output logic                 ser_load,
   output logic [DATAWIDTH-1:0] ser_data,
   output logic                 ser_en,
   input  logic                 ser_bit,
   input  logic                 ser_done,
   output logic                 tx,
   output logic                 busy
);

   state_t                 state;
   state_t                 state_nxt;
   logic                   hold_full;
   logic [DATAWIDTH-1:0]   hold_data;
   logic                   par_bit;
   logic                   par_en_q;
   logic                   accept;

   assign accept   = in_valid && !hold_full;
   assign in_ready = !hold_full;
   assign ser_data = hold_data;
   assign busy     = (state != IDLE);

   // Strobes are combinational so the serializer acts on the same tick edge
   // that changes state; ser_bit then lines up with the new bit period.
   always_comb begin
      state_nxt = state;
      ser_load  = 1'b0;
      ser_en    = 1'b0;
      if (baud_tick) begin
         case (state)
            IDLE: begin
               if (hold_full) begin
                  ser_load  = 1'b1;
                  state_nxt = START;
               end
            end
            START: begin
               ser_en    = 1'b1;
               state_nxt = DATA;
            end
            DATA: begin
               if (ser_done) begin
                  state_nxt = par_en_q ? PARITY : STOP;
               end else begin
                  ser_en = 1'b1;
               end
            end
            PARITY: begin
               state_nxt = STOP;
            end
            STOP: begin
               if (hold_full) begin
                  ser_load  = 1'b1;
                  state_nxt = START;
               end else begin
                  state_nxt = IDLE;
               end
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

   // Load and accept are mutually exclusive: load needs hold_full, accept needs it clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         hold_full <= 1'b0;
         hold_data <= '0;
         par_bit   <= 1'b0;
         par_en_q  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (ser_load) begin
            hold_full <= 1'b0;
            par_bit   <= (^hold_data) ^ par_odd;
            par_en_q  <= par_en;
         end else if (accept) begin
            hold_full <= 1'b1;
            hold_data <= in_data;
         end
      end
   end

   always_comb begin
      tx = TX_IDLE;
      case (state)
         IDLE:    tx = TX_IDLE;
         START:   tx = TX_START;
         DATA:    tx = ser_bit;
         PARITY:  tx = par_bit;
         STOP:    tx = TX_IDLE;
         default: tx = TX_IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with a behavioural shift serializer and a
// baud tick every 16 clocks; frames are checked bit by bit against fixed vectors.
module tb_uart_tx_ctrl;

   logic       clk;
   logic       rst;
   logic       baud_tick;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       par_en;
   logic       par_odd;
   logic       ser_load;
   logic [7:0] ser_data;
   logic       ser_en;
   logic       ser_bit;
   logic       ser_done;
   logic       tx;
   logic       busy;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   int tcnt   = 0;
   int n_en   = 0;
   int n_load = 0;
   int load_cyc[$];
   int acc_cyc[$];
   int rise_cyc[$];
   logic rdy_prev = 1'b1;

   uart_tx_ctrl #(.DATAWIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .baud_tick (baud_tick),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .par_en    (par_en),
      .par_odd   (par_odd),
      .ser_load  (ser_load),
      .ser_data  (ser_data),
      .ser_en    (ser_en),
      .ser_bit   (ser_bit),
      .ser_done  (ser_done),
      .tx        (tx),
      .busy      (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      tcnt      = (tcnt == 15) ? 0 : tcnt + 1;
      baud_tick = (tcnt == 15);
   end

   // Serializer model: load wins over shift, done after eight shifts.
   logic [7:0] sh;
   logic [3:0] scnt;
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         sh      <= '0;
         scnt    <= '0;
         ser_bit <= 1'b0;
      end else if (ser_load) begin
         sh   <= ser_data;
         scnt <= '0;
      end else if (ser_en) begin
         ser_bit <= sh[0];
         sh      <= sh >> 1;
         scnt    <= scnt + 4'd1;
      end
   end
   assign ser_done = (scnt == 4'd8);

   always begin
      @(negedge clk);
      #3;
      if (ser_en) n_en++;
      if (ser_load) begin
         n_load++;
         load_cyc.push_back(cyc);
      end
      if (in_valid && in_ready) acc_cyc.push_back(cyc);
      if (in_ready && !rdy_prev) rise_cyc.push_back(cyc);
      rdy_prev = in_ready;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic push(input logic [7:0] b);
      int k;
      in_data  = b;
      in_valid = 1'b1;
      k = 0;
      while (!in_ready && k < 400) begin
         @(negedge clk);
         k++;
      end
      check_val("accept_ready", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_tx_low();
      int k;
      k = 0;
      while (tx !== 1'b0 && k < 64) begin
         @(negedge clk);
         k++;
      end
      check_val("start_seen", tx, 0);
   endtask

   // Entered on the first negedge of the start bit; leaves on the last negedge of the stop bit.
   task automatic check_frame(input string tag, input logic [10:0] exp, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         check_val($sformatf("%s_b%0d_first", tag, i), tx, exp[i]);
         repeat (15) @(negedge clk);
         check_val($sformatf("%s_b%0d_last", tag, i), tx, exp[i]);
         if (i < nbits - 1) @(negedge clk);
      end
   endtask

   task automatic check_idle(input string tag);
      @(negedge clk);
      check_val({tag, "_tx_idle"}, tx, 1);
      check_val({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      rst      = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      par_en   = 1'b0;
      par_odd  = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rst_tx", tx, 1);
      check_val("rst_busy", busy, 0);
      check_val("rst_in_ready", in_ready, 1);
      check_val("rst_ser_load", ser_load, 0);
      check_val("rst_ser_en", ser_en, 0);
      check_val("rst_ser_data", ser_data, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // 0xA5, no parity
      n_en = 0;
      n_load = 0;
      push(8'hA5);
      wait_tx_low();
      check_frame("a5", 11'b01101001010, 10);
      check_idle("a5");
      check_val("a5_ser_en_cnt", n_en, 8);
      check_val("a5_ser_load_cnt", n_load, 1);

      // 0x07, even parity -> 1
      par_en  = 1'b1;
      par_odd = 1'b0;
      push(8'h07);
      wait_tx_low();
      check_frame("p07e", 11'b11000001110, 11);
      check_idle("p07e");

      // 0x07, odd parity -> 0
      par_odd = 1'b1;
      push(8'h07);
      wait_tx_low();
      check_frame("p07o", 11'b10000001110, 11);
      check_idle("p07o");

      // back-to-back 0x55 then 0x33
      par_en  = 1'b0;
      par_odd = 1'b0;
      load_cyc.delete();
      acc_cyc.delete();
      rise_cyc.delete();
      fork
         begin
            push(8'h55);
            push(8'h33);
         end
      join_none
      wait_tx_low();
      check_frame("b55", 11'b01010101010, 10);
      @(negedge clk);
      check_frame("b33", 11'b01001100110, 10);
      check_idle("b33");
      check_val("b2b_loads", load_cyc.size(), 2);
      check_val("b2b_accepts", acc_cyc.size(), 2);
      if (load_cyc.size() == 2 && acc_cyc.size() == 2) begin
         check_val("b2b_accept2_cycle", acc_cyc[1], load_cyc[0] + 1);
         begin
            int first_rise;
            first_rise = -1;
            foreach (rise_cyc[i])
               if (first_rise < 0 && rise_cyc[i] > acc_cyc[1]) first_rise = rise_cyc[i];
            check_val("b2b_ready_rise", first_rise, load_cyc[1] + 1);
         end
      end

      // reset in the middle of 0xFF with a second byte held
      fork
         begin
            push(8'hFF);
            push(8'h00);
         end
      join_none
      wait_tx_low();
      repeat (40) @(negedge clk);
      check_val("mid_busy", busy, 1);
      check_val("mid_hold_full", in_ready, 0);
      rst = 1'b0;
      #1;
      check_val("arst_tx", tx, 1);
      check_val("arst_busy", busy, 0);
      check_val("arst_in_ready", in_ready, 1);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      n_load = 0;
      repeat (48) @(negedge clk);
      check_val("post_rst_no_load", n_load, 0);
      check_val("post_rst_tx", tx, 1);
      push(8'h81);
      wait_tx_low();
      check_frame("r81", 11'b01100000010, 10);
      check_idle("r81");

      // par_en toggled mid-frame only affects the next frame
      par_en  = 1'b0;
      par_odd = 1'b0;
      push(8'h12);
      wait_tx_low();
      par_en = 1'b1;
      fork
         push(8'h12);
      join_none
      check_frame("t12a", 11'b01000100100, 10);
      @(negedge clk);
      check_frame("t12b", 11'b10000100100, 11);
      check_idle("t12b");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
